store_drain_queue: RTL and testbench
====================================

Name: store_drain_queue

Overview:
- Sits directly downstream of the store buffer.
- Accepts committed stores (valid/addr/data) in the same cycle the store buffer pops them, and queues them in a small FIFO.
- Drains the FIFO to the single-port data memory through a request/grant/acknowledge handshake.
- Committed stores are architectural state. They are never flushed; mispredict does not affect this block.

Parameters:
- WORD_SIZE_P, 16, data and address width in bits.
- DQ_ENTRY, 4, FIFO depth; a power of two, at least 2.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- sb_mem_v_i  input  1  committed store valid from the store buffer.
- sb_mem_addr_i  input  WORD_SIZE_P  committed store address.
- sb_mem_data_i  input  WORD_SIZE_P  committed store data.
- dq_ready_o  output  1  queue can accept a store this cycle; ROB commit of stores is gated by it.
- dq_empty_o  output  1  no queued or in-flight stores.
- mem_req_o  output  1  write request to data memory.
- mem_addr_o  output  WORD_SIZE_P  write address (head entry).
- mem_wdata_o  output  WORD_SIZE_P  write data (head entry).
- mem_gnt_i  input  1  memory accepted the request this cycle.
- mem_ack_i  input  1  memory completed the accepted write.
- ld_addr_i  input  WORD_SIZE_P  load address for forwarding lookup.
- ld_hit_o  output  1  load address matches a queued store.
- ld_data_o  output  WORD_SIZE_P  forwarded data.

Behaviour:
- Reset is asynchronous and active-high:
  - head, tail and count go to 0; state goes to IDLE; all entry valid bits go to 0.
  - While reset_i is high: mem_req_o=0, dq_ready_o=0, dq_empty_o=1, ld_hit_o=0, ld_data_o=0.
- State: count is $clog2(DQ_ENTRY)+1 bits. head and tail are $clog2(DQ_ENTRY) bits and wrap naturally modulo DQ_ENTRY.
- Enqueue:
  - dq_ready_o = (count != DQ_ENTRY), computed from the registered count only. A same-cycle pop gives no credit.
  - A push occurs when sb_mem_v_i && dq_ready_o. Entry[tail] <= {addr, data, valid=1}; tail++.
  - sb_mem_v_i while dq_ready_o=0 is a protocol violation (the upstream stage must hold commit). The store is dropped and the bench flags it.
- Drain FSM:
  - IDLE: mem_req_o=0. Go to REQ when count!=0 (registered), so the earliest request is the cycle after the push.
  - REQ: mem_req_o=1, mem_addr_o/mem_wdata_o = entry[head]. Hold stable until mem_gnt_i. On mem_gnt_i go to WAIT.
  - WAIT: mem_req_o=0. Wait for mem_ack_i. On ack: entry[head].valid<=0, head++, pop. Go to REQ if (count-1+push)!=0, else IDLE.
  - mem_gnt_i outside REQ and mem_ack_i outside WAIT are ignored.
  - Ack in the same cycle as gnt is not supported; ack arrives at least 1 cycle after gnt.
- Count and empty:
  - count_n = count + push - pop. A simultaneous push and pop leaves count unchanged.
  - dq_empty_o = (count==0), registered. The in-flight entry counts until acked.
- mem_addr_o and mem_wdata_o show entry[head] in every state. Their value is don't-care when count==0.
- Reset asserted mid-transaction abandons the in-flight write. Memory-side recovery is outside this block.

Optional Feature:
- Macro: STORE_DRAIN_LD_FWD_EN.
- Defined (combinational lookup over all valid entries, including the in-flight head):
  - ld_hit_o=1 if any entry address equals ld_addr_i.
  - ld_data_o is the data of the youngest match, i.e. the entry closest behind tail in age order.
  - Otherwise ld_hit_o=0 and ld_data_o=0.
- Not defined: ld_hit_o and ld_data_o are tied to 0. Loads must wait for dq_empty_o=1 before reading memory.

Test Plan:
- Single store: push addr=0x0010 data=0xBEEF at cycle 0; gnt at cycle 2; ack at cycle 4 -> mem_req_o high on cycles 1-2 with 0x0010/0xBEEF; dq_empty_o=1 from cycle 5.
- Fill: 4 back-to-back pushes with gnt held low -> dq_ready_o=0 after the 4th push. Then gnt/ack each one in turn -> memory receives the 4 writes in push order; dq_ready_o returns to 1 the cycle after the first ack.
- Wrap and simultaneous events: push on the same cycle as an ack with count=4 blocked and count=2 allowed -> count stays 2. Run 10 stores through -> head/tail wrap with FIFO order preserved.
- Forwarding (macro on): queue 0x0020=0x1111 then 0x0020=0x2222; ld_addr_i=0x0020 -> ld_hit_o=1, ld_data_o=0x2222. ld_addr_i=0x0030 -> ld_hit_o=0. After both acks, 0x0020 -> ld_hit_o=0.
- Forwarding (macro off): same stimulus -> ld_hit_o=0 throughout; dq_empty_o=0 until the last ack.
- Async reset while in WAIT with 3 entries queued -> within the reset cycle mem_req_o=0, dq_empty_o=1. After release, a later ack is ignored and a new push drains normally.

Source files
------------

// File: rtl/store_drain_queue.sv
// store_drain_queue: store FIFO draining to data memory via req/gnt/ack; STORE_DRAIN_LD_FWD_EN enables load forwarding
module store_drain_queue #(
    parameter int WORD_SIZE_P = 16,
    parameter int DQ_ENTRY = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sb_mem_v_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
    input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
    output logic                   dq_ready_o,
    output logic                   dq_empty_o,
    output logic                   mem_req_o,
    output logic [WORD_SIZE_P-1:0] mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_ack_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   ld_hit_o,
    output logic [WORD_SIZE_P-1:0] ld_data_o
);
    localparam int AW = $clog2(DQ_ENTRY);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state_q, state_n;
    logic [AW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q, count_n;
    logic [DQ_ENTRY-1:0]    vld_q;
    logic [WORD_SIZE_P-1:0] addr_q [DQ_ENTRY];
    logic [WORD_SIZE_P-1:0] data_q [DQ_ENTRY];
    logic                   push, pop;

    // ready comes from the registered count only, so a pop in the same cycle gives no credit
    assign dq_ready_o  = !reset_i && (count_q != CW'(DQ_ENTRY));
    assign push        = sb_mem_v_i && dq_ready_o;
    assign pop         = (state_q == WAIT) && mem_ack_i;
    assign count_n     = count_q + CW'(push) - CW'(pop);
    assign dq_empty_o  = (count_q == '0);
    assign mem_req_o   = (state_q == REQ);
    assign mem_addr_o  = addr_q[head_q];
    assign mem_wdata_o = data_q[head_q];

    // drain sequencing: request the head, wait for grant, then wait for completion
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    state_n = (count_n != '0) ? REQ : IDLE;
            REQ:     state_n = mem_gnt_i ? WAIT : REQ;
            WAIT:    state_n = mem_ack_i ? ((count_n != '0) ? REQ : IDLE) : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // control state: pointers, occupancy, valid bits and FSM state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
        end
    end

    // entry payload needs no reset; the valid bits and count guard it
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= sb_mem_addr_i;
            data_q[tail_q] <= sb_mem_data_i;
        end
    end

`ifdef STORE_DRAIN_LD_FWD_EN
    // scan oldest to youngest so the youngest matching store wins
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        for (int i = 0; i < DQ_ENTRY; i++) begin
            if (vld_q[head_q + AW'(i)] && addr_q[head_q + AW'(i)] == ld_addr_i) begin
                ld_hit_o  = 1'b1;
                ld_data_o = data_q[head_q + AW'(i)];
            end
        end
    end
`else
    logic ld_unused;
    assign ld_unused = ^{ld_addr_i, vld_q};
    assign ld_hit_o  = 1'b0;
    assign ld_data_o = '0;
`endif
endmodule

// File: tb/tb_store_drain_queue.sv
// tb_store_drain_queue: directed self-checking bench for store_drain_queue
module tb_store_drain_queue;
`ifdef STORE_DRAIN_LD_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        sb_mem_v_i;
    logic [15:0] sb_mem_addr_i, sb_mem_data_i;
    logic        dq_ready_o, dq_empty_o, mem_req_o;
    logic [15:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_ack_i;
    logic [15:0] ld_addr_i;
    logic        ld_hit_o;
    logic [15:0] ld_data_o;

    int n_checks = 0;
    int n_errors = 0;

    store_drain_queue dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .sb_mem_v_i(sb_mem_v_i), .sb_mem_addr_i(sb_mem_addr_i), .sb_mem_data_i(sb_mem_data_i),
        .dq_ready_o(dq_ready_o), .dq_empty_o(dq_empty_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i),
        .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        sb_mem_v_i = 1'b1;
        sb_mem_addr_i = a;
        sb_mem_data_i = d;
        #1 check("push_rdy", dq_ready_o, 1);
        step();
        sb_mem_v_i = 1'b0;
    endtask

    // grant and complete the next write; optionally push during the ack cycle
    task automatic drain_one(input logic [15:0] a, input logic [15:0] d, input logic er,
                             input logic pv, input logic [15:0] pa, input logic [15:0] pd);
        int n = 0;
        #1;
        while (!mem_req_o && n < 20) begin
            step();
            #1;
            n++;
        end
        check("drain_req", mem_req_o, 1);
        check("drain_addr", mem_addr_o, a);
        check("drain_data", mem_wdata_o, d);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        #1 check("drain_wait_req", mem_req_o, 0);
        step();
        mem_ack_i = 1'b1;
        sb_mem_v_i = pv;
        sb_mem_addr_i = pa;
        sb_mem_data_i = pd;
        #1 check("drain_ack_rdy", dq_ready_o, er);
        step();
        mem_ack_i = 1'b0;
        sb_mem_v_i = 1'b0;
    endtask

    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];

    initial begin
        int k, drained;
        logic ack_next;
        reset_i = 1'b1;
        sb_mem_v_i = 1'b0;
        sb_mem_addr_i = '0;
        sb_mem_data_i = '0;
        mem_gnt_i = 1'b0;
        mem_ack_i = 1'b0;
        ld_addr_i = '0;
        #3;
        check("rst_req", mem_req_o, 0);
        check("rst_rdy", dq_ready_o, 0);
        check("rst_empty", dq_empty_o, 1);
        check("rst_hit", ld_hit_o, 0);
        check("rst_ldata", ld_data_o, 0);
        step();
        reset_i = 1'b0;

        // single store with exact cycle timing
        sb_mem_v_i = 1'b1;
        sb_mem_addr_i = 16'h0010;
        sb_mem_data_i = 16'hBEEF;
        #1 check("c0_rdy", dq_ready_o, 1);
        check("c0_req", mem_req_o, 0);
        check("c0_empty", dq_empty_o, 1);
        step();
        sb_mem_v_i = 1'b0;
        #1 check("c1_req", mem_req_o, 1);
        check("c1_addr", mem_addr_o, 16'h0010);
        check("c1_data", mem_wdata_o, 16'hBEEF);
        check("c1_empty", dq_empty_o, 0);
        step();
        mem_gnt_i = 1'b1;
        #1 check("c2_req", mem_req_o, 1);
        step();
        mem_gnt_i = 1'b0;
        #1 check("c3_req", mem_req_o, 0);
        step();
        mem_ack_i = 1'b1;
        #1 check("c4_empty", dq_empty_o, 0);
        step();
        mem_ack_i = 1'b0;
        #1 check("c5_empty", dq_empty_o, 1);
        check("c5_req", mem_req_o, 0);

        // fill to full, then drain in push order
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        #1 check("full_rdy", dq_ready_o, 0);
        check("full_empty", dq_empty_o, 0);
        drain_one(16'h0100, 16'hA000, 1'b0, 1'b0, '0, '0);
        #1 check("rdy_after_ack", dq_ready_o, 1);
        for (int i = 1; i < 4; i++) drain_one(16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, '0, '0);
        #1 check("fill_done_empty", dq_empty_o, 1);

        // ack while full gives no credit; push+ack at count 2 keeps count 2
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i), 16'hC000 + 16'(i));
        drain_one(16'h0200, 16'hC000, 1'b0, 1'b0, '0, '0);
        drain_one(16'h0201, 16'hC001, 1'b1, 1'b0, '0, '0);
        drain_one(16'h0202, 16'hC002, 1'b1, 1'b1, 16'h0204, 16'hC004);
        #1 check("sim_empty2", dq_empty_o, 0);
        drain_one(16'h0203, 16'hC003, 1'b1, 1'b0, '0, '0);
        #1 check("sim_empty1", dq_empty_o, 0);
        drain_one(16'h0204, 16'hC004, 1'b1, 1'b0, '0, '0);
        #1 check("sim_empty0", dq_empty_o, 1);

        // ten stores streamed through with overlap; a queue tracks the expected order
        k = 0;
        drained = 0;
        ack_next = 1'b0;
        for (int c = 0; c < 60; c++) begin
            sb_mem_v_i = (k < 10) && dq_ready_o && (c % 3 != 2);
            sb_mem_addr_i = 16'h0300 + 16'(k);
            sb_mem_data_i = 16'h5000 + 16'(k);
            mem_gnt_i = mem_req_o;
            mem_ack_i = ack_next;
            ack_next = mem_gnt_i;
            #1;
            if (mem_gnt_i) begin
                check("wrap_addr", mem_addr_o, exp_a.size() ? exp_a.pop_front() : 16'hXXXX);
                check("wrap_data", mem_wdata_o, exp_d.size() ? exp_d.pop_front() : 16'hXXXX);
                drained++;
            end
            if (sb_mem_v_i) begin
                exp_a.push_back(sb_mem_addr_i);
                exp_d.push_back(sb_mem_data_i);
                k++;
            end
            step();
        end
        sb_mem_v_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_ack_i = 1'b0;
        #1 check("wrap_pushed", k, 10);
        check("wrap_drained", drained, 10);
        check("wrap_empty", dq_empty_o, 1);

        // forwarding lookup, youngest match wins
        push(16'h0020, 16'h1111);
        push(16'h0020, 16'h2222);
        ld_addr_i = 16'h0020;
        #1 check("fwd_hit", ld_hit_o, FWD);
        check("fwd_data", ld_data_o, FWD ? 16'h2222 : 16'h0000);
        ld_addr_i = 16'h0030;
        #1 check("fwd_miss_hit", ld_hit_o, 0);
        check("fwd_miss_data", ld_data_o, 0);
        ld_addr_i = 16'h0020;
        drain_one(16'h0020, 16'h1111, 1'b1, 1'b0, '0, '0);
        #1 check("fwd_mid_hit", ld_hit_o, FWD);
        check("fwd_mid_data", ld_data_o, FWD ? 16'h2222 : 16'h0000);
        check("fwd_mid_empty", dq_empty_o, 0);
        drain_one(16'h0020, 16'h2222, 1'b1, 1'b0, '0, '0);
        #1 check("fwd_done_hit", ld_hit_o, 0);
        check("fwd_done_empty", dq_empty_o, 1);

        // async reset in WAIT with three entries queued
        for (int i = 0; i < 3; i++) push(16'h0040 + 16'(i), 16'hD000 + 16'(i));
        ld_addr_i = 16'h0040;
        #1 check("ar_req", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        #1 check("ar_wait", mem_req_o, 0);
        #2 reset_i = 1'b1;
        #1 check("ar_rst_req", mem_req_o, 0);
        check("ar_rst_empty", dq_empty_o, 1);
        check("ar_rst_rdy", dq_ready_o, 0);
        check("ar_rst_hit", ld_hit_o, 0);
        check("ar_rst_ldata", ld_data_o, 0);
        step();
        reset_i = 1'b0;
        mem_ack_i = 1'b1;
        #1 check("ar_rel_rdy", dq_ready_o, 1);
        check("ar_rel_empty", dq_empty_o, 1);
        step();
        mem_ack_i = 1'b0;
        #1 check("ar_ack_ignored_req", mem_req_o, 0);
        check("ar_ack_ignored_empty", dq_empty_o, 1);
        push(16'h0050, 16'h7777);
        drain_one(16'h0050, 16'h7777, 1'b1, 1'b0, '0, '0);
        #1 check("ar_final_empty", dq_empty_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
